// File: rtl/match_result_arbiter_if.sv
// Bundle of match inputs, result-memory write handshake and status outputs
// shared by the result arbiter and its environment.
interface match_result_arbiter_if;
   logic [3:0]  match_in;
   logic        eop;
   logic        clear;
   logic        wr_ack;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  overflow;
   logic [15:0] drop_count;
   logic        busy;

   modport master (
      input  match_in, eop, clear, wr_ack,
      output wr_en, wr_addr, wr_data, overflow, drop_count, busy
   );

   modport slave (
      output match_in, eop, clear, wr_ack,
      input  wr_en, wr_addr, wr_data, overflow, drop_count, busy
   );
endinterface

// File: rtl/match_result_arbiter.sv
// Queues comparator match pulses per source and round-robins them into
// 32-bit result records written to a wrapping result-memory region.
//
// state   | meaning
// IDLE    | pick next pending source, latch record, raise wr_en
// WRITE   | hold wr_en/addr/data until wr_ack
// ADVANCE | retire the hit, bump slot index and address
module match_result_arbiter #(
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int          ADDR_DEPTH = 1024,
   parameter int          PEND_W     = 3
) (
   input logic                  clk,
   input logic                  rst,
   match_result_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(ADDR_DEPTH);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WRITE   = 2'd1;
   localparam logic [1:0] ADVANCE = 2'd2;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [1:0]        state;
   logic [PEND_W-1:0] pend     [4];
   logic [PEND_W-1:0] pend_nxt [4];
   logic [3:0]        pend_nz;
   logic [3:0]        inc;
   logic [3:0]        dec;
   logic [3:0]        drop;
   logic [2:0]        drop_num;
   logic [16:0]       drop_sum;
   logic [15:0]       drop_count_nxt;
   logic [1:0]        last_grant;
   logic [1:0]        src;
   logic [1:0]        scan_idx;
   logic [1:0]        grant_src;
   logic              grant_vld;
   logic [IDX_W-1:0]  slot;
   logic [IDX_W-1:0]  slot_inc;
   logic [15:0]       seq_num;
   logic              wr_en_q;
   logic [31:0]       wr_addr_q;
   logic [31:0]       wr_data_q;
   logic [3:0]        overflow_q;
   logic [15:0]       drop_count_q;

   assign inc = bus.match_in & {4{~bus.clear}};

   always_comb begin
      dec = '0;
      if (state == ADVANCE) dec[src] = 1'b1;
   end

   // A pulse and a retire on the same source cancel, so a full counter can
   // still accept a hit while its head record is being retired.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pend_nxt[i] = pend[i];
         drop[i]     = 1'b0;
         pend_nz[i]  = (pend[i] != '0);
         if (bus.clear) begin
            pend_nxt[i] = '0;
         end else if (inc[i] && !dec[i]) begin
            if (pend[i] == PEND_MAX) drop[i] = 1'b1;
            else                     pend_nxt[i] = pend[i] + PEND_W'(1);
         end else if (dec[i] && !inc[i] && pend_nz[i]) begin
            pend_nxt[i] = pend[i] - PEND_W'(1);
         end
      end
   end

   assign drop_num = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
   assign drop_sum = {1'b0, drop_count_q} + 17'(drop_num);
   assign drop_count_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   always_comb begin
      grant_vld = 1'b0;
      grant_src = last_grant;
      scan_idx  = last_grant;
      for (int k = 1; k <= 4; k++) begin
         scan_idx = last_grant + 2'(k);
         if (!grant_vld && pend_nz[scan_idx]) begin
            grant_vld = 1'b1;
            grant_src = scan_idx;
         end
      end
   end

   assign slot_inc = slot + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         for (int i = 0; i < 4; i++) pend[i] <= '0;
         last_grant   <= 2'd3;
         src          <= 2'd0;
         slot         <= '0;
         seq_num      <= 16'd0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= ADDR_BASE;
         wr_data_q    <= 32'd0;
         overflow_q   <= 4'd0;
         drop_count_q <= 16'd0;
      end else begin
         for (int i = 0; i < 4; i++) pend[i] <= pend_nxt[i];
         overflow_q   <= bus.clear ? 4'd0 : (overflow_q | drop);
         drop_count_q <= drop_count_nxt;
         if (bus.clear)    seq_num <= 16'd0;
         else if (bus.eop) seq_num <= seq_num + 16'd1;

         case (state)
            IDLE: begin
               // A flush takes priority over starting a new record.
               if (grant_vld && !bus.clear) begin
                  src       <= grant_src;
                  wr_data_q <= {grant_src, 14'd0, seq_num};
                  wr_en_q   <= 1'b1;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               if (bus.wr_ack) begin
                  wr_en_q <= 1'b0;
                  state   <= ADVANCE;
               end
            end
            ADVANCE: begin
               last_grant <= src;
               slot       <= slot_inc;
               wr_addr_q  <= ADDR_BASE + (32'(slot_inc) << 2);
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_count_q;
   assign bus.busy       = (state != IDLE) || (|pend_nz);
endmodule
